periph_timer_ctrl: RTL

Memory-mapped peripheral controller on the CPU data bus at base `0x40000000`. It owns the interval timer (TH/TL/TCON) that drives the CPU interrupt line, the 7-segment digit register, and the UART transmit handoff with a single-entry pending buffer. Firmware in the instruction ROM programs the timer with TH=-1000, TL=-1, TCON=3. Its ISR clears TCON bits 1–2, refreshes the digit register, and re-arms the timer. Register reads are combinational for the single-cycle datapath; all state updates happen on the rising clock edge.

---
 rtl/periph_timer_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/periph_timer_ctrl.sv
// periph_timer_ctrl: memory-mapped peripheral block on the CPU data bus.
// It holds the interval timer (TH/TL/TCON) that drives the interrupt line,
// the 7-segment digit register, and the UART transmit handoff. The UART
// side has a single-entry pending buffer for bytes written while busy.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   addr       in   byte address from the ALU
//   wdata      in   store data
//   mem_write  in   store strobe
//   mem_read   in   load strobe
//   rdata      out  load data (combinational)
//   irq        out  interrupt request, TCON[1] & TCON[2]
//   digi       out  digit register: [6:0] segments (active-low), [11:8] anodes
//   tx_start   out  one-cycle UART launch pulse
//   tx_data    out  byte to send, valid while tx_start is high
//   tx_busy    in   UART transmitter busy
module periph_timer_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [11:0] digi,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy
);

    localparam logic [3:0] OFF_TH   = 4'h0;
    localparam logic [3:0] OFF_TL   = 4'h1;
    localparam logic [3:0] OFF_TCON = 4'h2;
    localparam logic [3:0] OFF_DIGI = 4'h5;
    localparam logic [3:0] OFF_TXD  = 4'h6;
    localparam logic [3:0] OFF_UCON = 4'h8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StHold  = 2'd2
    } tx_state_e;

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [11:0] r_digi;
    logic        r_overrun;
    logic [7:0]  r_pend;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    tx_state_e   r_state;

    logic        w_hit;
    logic        w_wr;
    logic        w_we_th;
    logic        w_we_tl;
    logic        w_we_tcon;
    logic        w_we_digi;
    logic        w_we_txd;
    logic        w_we_ucon;
    logic        w_ovf;
    logic        w_tcon2_next;
    logic        w_busy;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Byte lane bits are not used for decoding.
    assign w_unused = ^addr[1:0];

    assign w_hit     = (addr[31:6] == BASE_ADDR[31:6]);
    assign w_wr      = mem_write & w_hit;
    assign w_we_th   = w_wr & (addr[5:2] == OFF_TH);
    assign w_we_tl   = w_wr & (addr[5:2] == OFF_TL);
    assign w_we_tcon = w_wr & (addr[5:2] == OFF_TCON);
    assign w_we_digi = w_wr & (addr[5:2] == OFF_DIGI);
    assign w_we_txd  = w_wr & (addr[5:2] == OFF_TXD);
    assign w_we_ucon = w_wr & (addr[5:2] == OFF_UCON);

    assign w_ovf = r_tcon[0] & (r_tl == 32'hFFFF_FFFF);

    // Status bit: an overflow seen this cycle wins over a software clear, so a
    // clear racing a new event never loses that event. Uses pre-write TCON[1].
    assign w_tcon2_next = (w_we_tcon ? wdata[2] : r_tcon[2]) | (w_ovf & r_tcon[1]);

    assign w_busy = (r_state == StHold) | r_tx_start | tx_busy;

    // Timer and digit registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th   <= 32'd0;
            r_tl   <= 32'd0;
            r_tcon <= 3'd0;
            r_digi <= 12'd0;
        end else begin
            if (w_we_th) begin
                r_th <= wdata;
            end
            // Software write beats reload, reload beats counting.
            if (w_we_tl) begin
                r_tl <= wdata;
            end else if (w_ovf) begin
                r_tl <= r_th;
            end else if (r_tcon[0]) begin
                r_tl <= r_tl + 32'd1;
            end
            if (w_we_tcon) begin
                r_tcon[1:0] <= wdata[1:0];
            end
            r_tcon[2] <= w_tcon2_next;
            if (w_we_digi) begin
                r_digi <= wdata[11:0];
            end
        end
    end

    // UART transmit handoff FSM with registered launch outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_pend     <= 8'd0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'd0;
            r_overrun  <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_we_txd) begin
                        if (tx_busy) begin
                            r_pend  <= wdata[7:0];
                            r_state <= StHold;
                        end else begin
                            r_tx_data  <= wdata[7:0];
                            r_tx_start <= 1'b1;
                            r_state    <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    r_state <= StIdle;
                end
                StHold: begin
                    if (!tx_busy) begin
                        r_tx_data  <= r_pend;
                        r_tx_start <= 1'b1;
                        r_state    <= StIssue;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
            // A byte arriving while one is in flight is dropped and flagged.
            if (w_we_txd && (r_state != StIdle)) begin
                r_overrun <= 1'b1;
            end else if (w_we_ucon) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (mem_read && w_hit) begin
            case (addr[5:2])
                OFF_TH:   w_rdata = r_th;
                OFF_TL:   w_rdata = r_tl;
                OFF_TCON: w_rdata = {29'd0, r_tcon};
                OFF_DIGI: w_rdata = {20'd0, r_digi};
                OFF_UCON: w_rdata = {30'd0, r_overrun, w_busy};
                default:  w_rdata = 32'd0;
            endcase
        end
    end

    assign rdata    = w_rdata;
    assign irq      = r_tcon[1] & r_tcon[2];
    assign digi     = r_digi;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

endmodule
